control_unit: RTL
=================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 8: width of the program counter and of instr_addr.
REQ-002 SHALL have port clock  input  1  the single rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port instr  input  16  instruction word at instr_addr, from a combinational-read program ROM.
REQ-005 SHALL have port zero_flag  input  1  datapath flag, high when alu_out == 0.
REQ-006 SHALL have port pos_flag  input  1  datapath flag, high when alu_out[15] == 0.
REQ-007 SHALL have port instr_addr  output  PC_WIDTH  current program counter.
REQ-008 SHALL have port rf_write  output  1  register-file write enable.
REQ-009 SHALL have ports rs_addr, rt_addr, rd_addr  output  3 each  register selects.
REQ-010 SHALL have port imm_data  output  16  immediate value to the datapath.
REQ-011 SHALL have port alu_sel  output  4  ALU operation: ADD=0, SUB=1, AND=2, OR=3, PASS_B=4.
REQ-012 SHALL have ports imm_sel, mem_write, mem_sel  output  1 each  datapath mux and memory controls.
REQ-013 SHALL have port halted  output  1  high while in the HALT state.

Function
REQ-014 SHALL decode the instruction register (IR) fields as follows: op=IR[15:12], rd=IR[11:9], rs=IR[8:6], rt=IR[5:3], imm6=IR[5:0] sign-extended to 16 bits, and jump target=IR[7:0].
REQ-015 SHALL implement opcodes 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 ADDI, 6 LD, 7 ST, 8 BEQZ, 9 BPOS, A JMP and F HALT; opcodes B-E SHALL execute as NOP.
REQ-016 SHALL implement the FSM states FETCH, DECODE, EXECUTE, MEM, WRITEBACK and HALT.
REQ-017 In FETCH, the block SHALL latch IR<=instr and set PC<=PC+1 (modulo 2^PC_WIDTH), then go to DECODE.
REQ-018 DECODE SHALL always go to EXECUTE, except that op F goes to HALT.
REQ-019 EXECUTE transitions SHALL be:
- ALU ops and ADDI -> WRITEBACK.
- LD and ST -> MEM.
- Branches, JMP and NOP -> FETCH.
REQ-020 MEM transitions SHALL be: LD -> WRITEBACK; ST -> FETCH.
REQ-021 WRITEBACK SHALL go to FETCH.
REQ-022 HALT SHALL be left only by reset.
REQ-023 Instruction latencies in clocks SHALL be: ALU/ADDI=4, LD=5, ST=4, branch/JMP/NOP=3, and HALT reached 2 cycles after fetch.
REQ-024 From DECODE through WRITEBACK, rs_addr, rt_addr, rd_addr, imm_data, alu_sel, imm_sel and mem_sel SHALL be held stable from IR.
REQ-025 Field mapping per instruction class SHALL be:
- R-type: imm_sel=0, alu_sel per op.
- ADDI and LD: imm_sel=1, imm_data=imm6, alu_sel=ADD.
- ST: rt_addr=rt, imm_sel=0, alu_sel=PASS_B, giving mem[rt] <= rs.
- BEQZ and BPOS: imm_sel=1, imm_data=0, alu_sel=ADD.
REQ-026 mem_sel SHALL be 1 only for LD; rf_write SHALL be 1 only in WRITEBACK; mem_write SHALL be 1 only in MEM for ST; all three SHALL be single-cycle pulses.
REQ-027 Branches SHALL sample the flags at the end of EXECUTE: BEQZ is taken if zero_flag=1, BPOS is taken if pos_flag=1.
- Taken: PC <= PC + sext(imm6), modulo 2^PC_WIDTH, where PC is the already-incremented value.
- Not taken: PC is unchanged.
REQ-028 JMP SHALL set PC<=target in EXECUTE.
REQ-029 In FETCH, DECODE and HALT, rf_write and mem_write SHALL be 0.
REQ-030 An instruction with rd=0 SHALL still write; the controller does not special-case any register.
REQ-031 PC wrap from 2^PC_WIDTH-1 to 0 SHALL occur silently.

Reset
REQ-032 Reset assertion SHALL immediately, without waiting for a clock, force state=FETCH, PC=0, IR=0, halted=0 and all control outputs to 0.
REQ-033 Reset asserted mid-instruction, including during MEM or WRITEBACK, SHALL abort the instruction with no rf_write or mem_write pulse.
REQ-034 After reset deasserts, the first FETCH SHALL occur on the next rising clock edge.

Verification
REQ-035 Apply reset, then ADDI r1,r0,5 (instr 0x5205) with the ROM returning it -> rf_write pulses in cycle 4 with rd_addr=1, imm_data=0x0005, imm_sel=1, alu_sel=0; instr_addr=1 afterwards.
REQ-036 Execute ST r2->[r3] followed by LD r4,[r0+3] -> mem_write pulses exactly once in the ST MEM cycle with rt_addr=3 and alu_sel=4; the LD WRITEBACK shows mem_sel=1, rf_write=1, rd_addr=4.
REQ-037 Execute BEQZ at PC=10 with imm6=-2 and zero_flag=1 -> next instr_addr=9; the same instruction with zero_flag=0 -> next instr_addr=11.
REQ-038 Execute JMP 0xFF, then a NOP at 0xFF -> PC wraps to 0x00; opcode 0xC behaves as a 3-cycle NOP.
REQ-039 Execute HALT (0xF000) -> halted=1 from cycle 3 and stays high for 20 cycles with no strobes; asserting reset then clears halted asynchronously.
REQ-040 Assert reset during the LD MEM cycle -> no rf_write pulse, and PC=0 and halted=0 immediately, before the next clock edge.

Source files
------------

// File: rtl/control_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : control_unit_if
//  Description : Bundle between the multi-cycle control unit and its
//                datapath / program ROM.
//                master : control unit side (drives PC and control lines)
//                slave  : datapath side (drives instr and ALU flags)
//  Ports       : instr, zero_flag, pos_flag            -> into controller
//                instr_addr, rf_write, rs/rt/rd_addr,
//                imm_data, alu_sel, imm_sel, mem_write,
//                mem_sel, halted                       -> out of controller
//  Revision    : 1.0  initial release
// ============================================================================
interface control_unit_if #(
    parameter int PC_WIDTH = 8
);
    logic [15:0]         instr;
    logic                zero_flag;
    logic                pos_flag;
    logic [PC_WIDTH-1:0] instr_addr;
    logic                rf_write;
    logic [2:0]          rs_addr;
    logic [2:0]          rt_addr;
    logic [2:0]          rd_addr;
    logic [15:0]         imm_data;
    logic [3:0]          alu_sel;
    logic                imm_sel;
    logic                mem_write;
    logic                mem_sel;
    logic                halted;

    modport master (
        input  instr, zero_flag, pos_flag,
        output instr_addr, rf_write, rs_addr, rt_addr, rd_addr,
               imm_data, alu_sel, imm_sel, mem_write, mem_sel, halted
    );

    modport slave (
        output instr, zero_flag, pos_flag,
        input  instr_addr, rf_write, rs_addr, rt_addr, rd_addr,
               imm_data, alu_sel, imm_sel, mem_write, mem_sel, halted
    );
endinterface
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : control_unit
//  Description : Multi-cycle controller for a 16-bit accumulator-less RISC
//                datapath. FSM: FETCH -> DECODE -> EXECUTE -> (MEM) ->
//                (WRITEBACK) -> FETCH, plus a sticky HALT state.
//  Ports       : clock  - rising-edge clock
//                reset  - asynchronous active-high reset
//                bus    - control_unit_if.master (ROM word, flags in;
//                         PC, register selects, immediate, ALU/mem
//                         controls and halted out)
//  Revision    : 1.0  initial release
// ============================================================================
module control_unit #(
    parameter int PC_WIDTH = 8
) (
    input  logic           clock,
    input  logic           reset,
    control_unit_if.master bus
);
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_ADDI = 4'h5;
    localparam logic [3:0] OP_LD   = 4'h6;
    localparam logic [3:0] OP_ST   = 4'h7;
    localparam logic [3:0] OP_BEQZ = 4'h8;
    localparam logic [3:0] OP_BPOS = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_AND    = 4'd2;
    localparam logic [3:0] ALU_OR     = 4'd3;
    localparam logic [3:0] ALU_PASS_B = 4'd4;

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEM       = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_t;

    state_t              state_q;
    logic [PC_WIDTH-1:0] pc_q;
    logic [15:0]         ir_q;
    logic [15:0]         imm_q;
    logic [3:0]          alu_q;
    logic                imm_sel_q;
    logic                mem_sel_q;
    logic                rf_write_q;
    logic                mem_write_q;
    logic                halted_q;

    // Datapath controls are decoded from the ROM word during FETCH and
    // registered together with IR, so they are valid from DECODE onward.
    logic [15:0] imm_d;
    logic [3:0]  alu_d;
    logic        imm_sel_d;
    logic        mem_sel_d;

    always_comb begin
        imm_d     = {{10{bus.instr[5]}}, bus.instr[5:0]};
        alu_d     = ALU_ADD;
        imm_sel_d = 1'b0;
        mem_sel_d = 1'b0;
        case (bus.instr[15:12])
            OP_SUB:  alu_d = ALU_SUB;
            OP_AND:  alu_d = ALU_AND;
            OP_OR:   alu_d = ALU_OR;
            OP_ADDI: imm_sel_d = 1'b1;
            OP_LD: begin
                imm_sel_d = 1'b1;
                mem_sel_d = 1'b1;
            end
            OP_ST:   alu_d = ALU_PASS_B;
            // Branches test rs + 0 so the flags reflect rs itself.
            OP_BEQZ, OP_BPOS: begin
                imm_sel_d = 1'b1;
                imm_d     = 16'h0000;
            end
            default: ;
        endcase
    end

    // Sign-extended imm6 and zero-extended 8-bit jump target, sized to PC.
    logic [PC_WIDTH-1:0] br_off;
    logic [PC_WIDTH-1:0] jmp_tgt;

    for (genvar gi = 0; gi < PC_WIDTH; gi++) begin : g_pc_bits
        if (gi < 6) begin : g_off_lo
            assign br_off[gi] = ir_q[gi];
        end else begin : g_off_sx
            assign br_off[gi] = ir_q[5];
        end
        if (gi < 8) begin : g_tgt_lo
            assign jmp_tgt[gi] = ir_q[gi];
        end else begin : g_tgt_hi
            assign jmp_tgt[gi] = 1'b0;
        end
    end

    logic [3:0] ir_op;
    logic       br_taken;
    assign ir_op    = ir_q[15:12];
    assign br_taken = ((ir_op == OP_BEQZ) && bus.zero_flag) ||
                      ((ir_op == OP_BPOS) && bus.pos_flag);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_FETCH;
            pc_q        <= '0;
            ir_q        <= '0;
            imm_q       <= '0;
            alu_q       <= '0;
            imm_sel_q   <= 1'b0;
            mem_sel_q   <= 1'b0;
            rf_write_q  <= 1'b0;
            mem_write_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            // Strobes are one-cycle pulses unless re-armed below.
            rf_write_q  <= 1'b0;
            mem_write_q <= 1'b0;
            case (state_q)
                S_FETCH: begin
                    ir_q      <= bus.instr;
                    pc_q      <= pc_q + PC_WIDTH'(1);
                    imm_q     <= imm_d;
                    alu_q     <= alu_d;
                    imm_sel_q <= imm_sel_d;
                    mem_sel_q <= mem_sel_d;
                    state_q   <= S_DECODE;
                end
                S_DECODE: begin
                    if (ir_op == OP_HALT) begin
                        state_q  <= S_HALT;
                        halted_q <= 1'b1;
                    end else begin
                        state_q  <= S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    case (ir_op)
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: begin
                            state_q    <= S_WRITEBACK;
                            rf_write_q <= 1'b1;
                        end
                        OP_LD: state_q <= S_MEM;
                        OP_ST: begin
                            state_q     <= S_MEM;
                            mem_write_q <= 1'b1;
                        end
                        OP_BEQZ, OP_BPOS: begin
                            // pc_q already points past the branch here.
                            if (br_taken) begin
                                pc_q <= pc_q + br_off;
                            end
                            state_q <= S_FETCH;
                        end
                        OP_JMP: begin
                            pc_q    <= jmp_tgt;
                            state_q <= S_FETCH;
                        end
                        default: state_q <= S_FETCH;
                    endcase
                end
                S_MEM: begin
                    if (ir_op == OP_LD) begin
                        state_q    <= S_WRITEBACK;
                        rf_write_q <= 1'b1;
                    end else begin
                        state_q    <= S_FETCH;
                    end
                end
                S_WRITEBACK: state_q <= S_FETCH;
                S_HALT:      state_q <= S_HALT;
                default:     state_q <= S_FETCH;
            endcase
        end
    end

    assign bus.instr_addr = pc_q;
    assign bus.rd_addr    = ir_q[11:9];
    assign bus.rs_addr    = ir_q[8:6];
    assign bus.rt_addr    = ir_q[5:3];
    assign bus.imm_data   = imm_q;
    assign bus.alu_sel    = alu_q;
    assign bus.imm_sel    = imm_sel_q;
    assign bus.mem_sel    = mem_sel_q;
    assign bus.rf_write   = rf_write_q;
    assign bus.mem_write  = mem_write_q;
    assign bus.halted     = halted_q;

endmodule
`default_nettype wire
